// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 window feeder: FSM state encodings, default
// image geometry, window length and the coordinate/tag types carried through
// the outstanding-window FIFO.
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;
  localparam int WIN_LEN   = 9;   // pixels per serial 3x3 window burst
  localparam int COORD_W   = 8;

  typedef logic [COORD_W-1:0] coord_t;

  // Centre coordinate of a window in flight through the filter.
  typedef struct packed {
    coord_t x;
    coord_t y;
  } tag_t;

  // Feeder FSM, legacy-compatible constant encoding.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_LOAD   = 2'd0;
  localparam fsm_state_t ST_STREAM = 2'd1;
  localparam fsm_state_t ST_DRAIN  = 2'd2;
  localparam fsm_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/coord_fifo.sv
// ---------------------------------------------------------------------------
// coord_fifo
// Synchronous FIFO of window centre tags {x,y}. A push into a full FIFO is
// dropped unless a pop happens in the same cycle; a pop of an empty FIFO is
// ignored. Simultaneous push and pop leaves the count unchanged.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write push_tag at the tail
//   push_tag   tag to write
//   pop        remove the head entry
//   head       current head entry (valid while !empty)
//   full       DEPTH entries held
//   empty      no entries held
// ---------------------------------------------------------------------------
module coord_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  tag_t             slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push would need.
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  // NOTE: storage arrays carry no reset; count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_tag;
  end

  // NOTE: sequential state is assigned with <= so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// ---------------------------------------------------------------------------
// conv_window_feeder
// Loads a raster-scan frame into a local store, then streams every interior
// 3x3 window to the Gaussian filter as a back-to-back 9-pixel serial burst
// (column-major, top to bottom). Each window's centre is queued as a tag and
// paired with the filter result when the filter pulses ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_pix      source pixel stream (raster order)
//   in_ready              feeder is accepting pixels (LOAD state)
//   d, start              serial window pixel and its qualifier to the filter
//   f_ready, f_r          filter result strobe and value
//   res_valid             one-cycle result strobe
//   res_pix, res_x, res_y filtered pixel and its centre coordinate
//   frame_done            one-cycle pulse once the last result of a frame is out
//   err                   sticky: result with no tag, or tag pushed into full FIFO
// ---------------------------------------------------------------------------
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int TAG_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_pix,
  output logic       in_ready,
  output logic [7:0] d,
  output logic       start,
  input  logic       f_ready,
  input  logic [7:0] f_r,
  output logic       res_valid,
  output logic [7:0] res_pix,
  output logic [7:0] res_x,
  output logic [7:0] res_y,
  output logic       frame_done,
  output logic       err
);

  localparam int                NPIX     = IMG_W * IMG_H;
  localparam int                ADDR_W   = $clog2(NPIX);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam coord_t            X_LAST   = coord_t'(IMG_W - 2);
  localparam coord_t            Y_LAST   = coord_t'(IMG_H - 2);
  localparam coord_t            C_ONE    = coord_t'(1);

  logic [7:0]        mem [NPIX];
  fsm_state_t        state;
  fsm_state_t        state_n;
  logic [ADDR_W-1:0] idx;

  // Position of the pixel currently on d: window centre (wx,wy) and the
  // row/column offset (kr,kc) inside the window; kr runs fastest.
  logic [1:0]        kr;
  logic [1:0]        kc;
  coord_t            wx;
  coord_t            wy;

  // Position of the pixel to be launched onto d at the next edge.
  logic [1:0]        sel_kr;
  logic [1:0]        sel_kc;
  coord_t            sel_x;
  coord_t            sel_y;
  int                row_i;
  int                col_i;
  logic [ADDR_W-1:0] rd_addr;

  logic              wr_en;
  logic              last_wr;
  logic              at_final;
  logic              emit;
  logic              push;
  logic              pop_ok;
  logic              push_drop;
  logic              fifo_full;
  logic              fifo_empty;
  tag_t              head;

  assign wr_en    = in_valid && in_ready;
  assign last_wr  = wr_en && (idx == LAST_IDX);
  assign at_final = (kr == 2'd2) && (kc == 2'd2) && (wx == X_LAST) && (wy == Y_LAST);
  // Launch a pixel on the edge that leaves LOAD and on every STREAM edge
  // except the one after the final pixel of the final window.
  assign emit     = ((state == ST_LOAD) && last_wr) ||
                    ((state == ST_STREAM) && !at_final);
  assign push     = emit && (sel_kr == 2'd0) && (sel_kc == 2'd0);

  // Next window position: the first window when leaving LOAD, otherwise the
  // successor of the pixel now on d.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_kr = 2'd0;
    sel_kc = 2'd0;
    sel_x  = C_ONE;
    sel_y  = C_ONE;
    if (state == ST_STREAM) begin
      sel_kr = kr;
      sel_kc = kc;
      sel_x  = wx;
      sel_y  = wy;
      if (kr != 2'd2) begin
        sel_kr = kr + 2'd1;
      end else begin
        sel_kr = 2'd0;
        if (kc != 2'd2) begin
          sel_kc = kc + 2'd1;
        end else begin
          sel_kc = 2'd0;
          if (wx != X_LAST) begin
            sel_x = wx + C_ONE;
          end else begin
            sel_x = C_ONE;
            sel_y = wy + C_ONE;
          end
        end
      end
    end
  end

  assign row_i   = int'(sel_y) + int'(sel_kr) - 1;
  assign col_i   = int'(sel_x) + int'(sel_kc) - 1;
  assign rd_addr = ADDR_W'(row_i * IMG_W + col_i);

  always_comb begin
    state_n = state;
    case (state)
      ST_LOAD:   if (last_wr)    state_n = ST_STREAM;
      ST_STREAM: if (at_final)   state_n = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty) state_n = ST_DONE;
      default:                   state_n = ST_LOAD;
    endcase
  end

  // Frame store write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= in_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      idx        <= '0;
      kr         <= 2'd0;
      kc         <= 2'd0;
      wx         <= C_ONE;
      wy         <= C_ONE;
      d          <= 8'd0;
      start      <= 1'b0;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready   <= (state_n == ST_LOAD);
      frame_done <= (state_n == ST_DONE);
      if (state == ST_DONE) idx <= '0;
      else if (wr_en)       idx <= idx + ADDR_ONE;
      if (emit) begin
        d     <= mem[rd_addr];
        start <= 1'b1;
        kr    <= sel_kr;
        kc    <= sel_kc;
        wx    <= sel_x;
        wy    <= sel_y;
      end else begin
        d     <= 8'd0;
        start <= 1'b0;
      end
    end
  end

  coord_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag ('{x: sel_x, y: sel_y}),
    .pop      (pop_ok),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A result with no outstanding tag is an error and produces no output.
  assign pop_ok    = f_ready && !fifo_empty;
  assign push_drop = push && fifo_full && !pop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_pix   <= 8'd0;
      res_x     <= 8'd0;
      res_y     <= 8'd0;
      err       <= 1'b0;
    end else begin
      res_valid <= pop_ok;
      if (pop_ok) begin
        res_pix <= f_r;
        res_x   <= head.x;
        res_y   <= head.y;
      end
      if ((f_ready && fifo_empty) || push_drop) err <= 1'b1;
    end
  end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Frame-side companion to the 3x3 Gaussian systolic filter. Accepts a raster-scan image into an internal frame store, then streams every interior 3x3 window to the filter as a serial 9-pixel burst under `start`. It collects each filtered result on the filter's `ready` pulse and re-emits it tagged with its centre coordinate. It sits between the pixel source and the filter, closing the loop on both sides of the filter's `d`/`start`/`r`/`ready` interface.

## Interface
- `IMG_W`, 8, image width in pixels (≥3)
- `IMG_H`, 8, image height in pixels (≥3)
- `TAG_DEPTH`, 4, outstanding-window tag FIFO depth (power of 2)
- Reset: `rst`, synchronous, active-high. Clock: `clk`.
- `clk` in 1 system clock
- `rst` in 1 synchronous active-high reset
- `in_valid` in 1 source pixel valid
- `in_pix` in 8 source pixel, raster order
- `in_ready` out 1 feeder accepts a pixel this cycle
- `d` out 8 serial window pixel to filter
- `start` out 1 high while `d` carries window pixels
- `f_ready` in 1 filter result-valid pulse
- `f_r` in 8 filter result, valid with `f_ready`
- `res_valid` out 1 one-cycle result strobe
- `res_pix` out 8 filtered pixel
- `res_x` out 8 centre column of result
- `res_y` out 8 centre row of result
- `frame_done` out 1 one-cycle pulse after last result of a frame
- `err` out 1 sticky protocol error

## Operation
- FSM states: LOAD, STREAM, DRAIN, DONE.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid`&`in_ready` writes `mem[idx]` and increments `idx`.
  - The write of pixel `IMG_W*IMG_H-1` moves the FSM to STREAM.
- STREAM:
  - Windows are centred at (x,y) for x=1..IMG_W-2 and y=1..IMG_H-2, raster order (x fastest).
  - Each window is 9 consecutive cycles, k=0..8, column-major, top to bottom: column x-1 (rows y-1,y,y+1), then column x, then column x+1.
  - Windows go back-to-back with `start`=1 continuously; no idle cycles.
  - At k=0 of each window, push (x,y) into the tag FIFO.
  - After k=8 of the last window, move to DRAIN.
- DRAIN: `start`=0, `d`=0. Wait until the tag FIFO is empty, then move to DONE.
- DONE: pulse `frame_done` for one cycle, clear `idx`, return to LOAD.
- Result path:
  - On `f_ready`, register `f_r` and pop the FIFO head.
  - Next cycle: `res_valid`=1, `res_pix`=registered `f_r`, `res_x`/`res_y`=popped tag.
  - Results are accepted in any FSM state.
- Errors (`err` set, sticky until `rst`):
  - `f_ready` with the FIFO empty: no pop, no `res_valid`.
  - Push into a full FIFO: tag dropped.
- Simultaneous push and pop in one cycle is legal and leaves the count unchanged.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 the cycle after; `d`=0, `start`=0, `res_valid`=0, `res_pix`/`res_x`/`res_y`=0, `frame_done`=0, `err`=0; FSM=LOAD; FIFO empty; `idx`=0.
- `d` and `start` are registered. Window pixel k appears on `d` in the same cycle `start`=1 for that k.
- First `start` rises the cycle after the last LOAD write.
- STREAM length is exactly 9·(IMG_W-2)·(IMG_H-2) cycles (324 for defaults).
- Latency from `f_ready` to `res_valid` is 1 cycle.
- `rst` mid-frame: abandon the frame, empty the FIFO, drop `start` the next cycle, and ignore in-flight results (they set `err` if they arrive later).
- Address arithmetic: `mem` index = row·IMG_W + col, width $clog2(IMG_W*IMG_H). Coordinates are zero-extended to 8 bits.

## Structure
- Package `conv_pkg`: FSM state enum, default `IMG_W`/`IMG_H`, window length constant 9, coordinate type (8 bits).
- Sub-module `coord_fifo`: synchronous FIFO of {x,y}, depth `TAG_DEPTH`, with push/pop/full/empty.
- Frame store is an inferred register/RAM array inside the top module.

## Test plan
- Uniform image, all pixels 0x40, with a behavioural filter model (1-2-1/2-4-2/1-2-1, >>4, fixed latency 12) -> 36 results, each `res_pix`=0x40, coordinates (1,1)…(6,6) in raster order, then one `frame_done`, `err`=0.
- Ramp image, pix = x+8y -> first window on `d` reads 0,8,16,1,9,17,2,10,18; second window starts 1,9,17; `start` stays high for 324 cycles.
- Impulse: 0xFF at (3,3), all others 0 -> `res_pix` at (3,3)=0x3F, at (2,3)=0x1F, at (2,2)=0x0F, all non-neighbours 0.
- `in_valid` toggled with random gaps during LOAD -> identical `d` sequence to the gap-free run; STREAM begins exactly one cycle after the 64th accepted pixel.
- `f_ready` pulsed during LOAD with the FIFO empty -> `err`=1, no `res_valid`; `err` stays 1 until `rst`.
- `rst` asserted at window 10, k=4 -> next cycle `start`=0 and `in_ready`=1 (after reset); a following full frame produces 36 correct results.
